// File: rtl/design_18_pkg.sv
// Shared types and defaults for the design_18 request scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package design_18_pkg;

    localparam int W_DEF   = 16;
    localparam int N_DEF   = 4;
    localparam int TMO_DEF = 15;

    // Wait counter is sized for the largest legal timeout (255).
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Next index after idx, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/design_18_rr_pick.sv
// Round-robin pick: first set request bit at or after ptr, wrapping modulo N.
// Latency: combinational.
// Backpressure: none; any=0 when no request is pending.
module design_18_rr_pick
    import design_18_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] winner,
    output logic          any
);

    // Scan offsets from far to near so the nearest set bit to ptr wins.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                winner = PW'((int'(ptr) + i) % N);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/design_18_sched.sv
// Arbitrates N requesters onto one shared datapath and returns its result.
// Latency: gnt/dp_start 1 cycle after req sampled in IDLE; rsp 1 cycle after dp_valid.
// Backpressure: one op in flight; requests wait in IDLE, timeout after TMO WAIT cycles.
module design_18_sched
    import design_18_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int N   = N_DEF,
    parameter int TMO = TMO_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic [N-1:0]   gnt,
    output logic           dp_start,
    output logic [W-1:0]   dp_a,
    output logic [W-1:0]   dp_b,
    input  logic           dp_valid,
    input  logic [W-1:0]   dp_y,
    output logic [N-1:0]   rsp_valid,
    output logic [W-1:0]   rsp_y,
    output logic           busy,
    output logic           tmo_err
);

    localparam int               PW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TMO);
    localparam logic [N-1:0]     ONE_N = N'(1);

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    owner;
    logic [CNT_W-1:0] cnt;
    logic [PW-1:0]    win_idx;
    logic             win_any;

    design_18_rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (win_idx),
        .any    (win_any)
    );

    // Busy is a pure decode of the state register.
    assign busy = (state != S_IDLE);

    // Scheduler FSM; all pulse outputs default low so each lasts one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            owner     <= '0;
            cnt       <= '0;
            dp_a      <= '0;
            dp_b      <= '0;
            rsp_y     <= '0;
            gnt       <= '0;
            dp_start  <= 1'b0;
            rsp_valid <= '0;
            tmo_err   <= 1'b0;
        end else begin
            gnt       <= '0;
            dp_start  <= 1'b0;
            rsp_valid <= '0;
            tmo_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_any) begin
                        dp_a     <= req_a[win_idx*W +: W];
                        dp_b     <= req_b[win_idx*W +: W];
                        owner    <= win_idx;
                        ptr      <= PW'(wrap_inc(int'(win_idx), N));
                        gnt      <= ONE_N << win_idx;
                        dp_start <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (dp_valid) begin
                        rsp_y     <= dp_y;
                        rsp_valid <= ONE_N << owner;
                        state     <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        // Give up once the datapath has had TMO WAIT cycles.
                        if (cnt + CNT_W'(1) == TMO_C) begin
                            tmo_err <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_design_18_sched.sv
// Directed bench for design_18_sched with hand-computed expectations.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: datapath stub is driven directly by the stimulus sequence.
module tb_design_18_sched;

    localparam int W = 16;
    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   gnt;
    logic           dp_start;
    logic [W-1:0]   dp_a;
    logic [W-1:0]   dp_b;
    logic           dp_valid;
    logic [W-1:0]   dp_y;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_y;
    logic           busy;
    logic           tmo_err;

    int n_chk;
    int n_bad;

    design_18_sched #(.W(W), .N(N), .TMO(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt       (gnt),
        .dp_start  (dp_start),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_valid  (dp_valid),
        .dp_y      (dp_y),
        .rsp_valid (rsp_valid),
        .rsp_y     (rsp_y),
        .busy      (busy),
        .tmo_err   (tmo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // One complete op from an IDLE cycle; datapath answers in the first WAIT cycle.
    task automatic op(input string tag, input logic [N-1:0] r, input logic [N-1:0] eg,
                      input logic [W-1:0] y);
        req = r;
        tick();
        chk({tag, "_gnt"}, gnt, eg);
        chk({tag, "_start"}, dp_start, 1'b1);
        req = '0;
        tick();
        dp_valid = 1'b1;
        dp_y     = y;
        tick();
        dp_valid = 1'b0;
        chk({tag, "_rsp"}, rsp_valid, eg);
        chk({tag, "_rsp_y"}, rsp_y, y);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        req      = '0;
        req_a    = '0;
        req_b    = '0;
        dp_valid = 1'b0;
        dp_y     = '0;
        for (int i = 0; i < N; i++) set_ops(i, W'(16'h10 + i), W'(16'h20 + i));
        set_ops(0, 16'h0003, 16'h0004);
        set_ops(3, 16'h0055, 16'h0066);

        // Reset state
        #3;
        chk("rst_gnt", gnt, 0);
        chk("rst_start", dp_start, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tmo", tmo_err, 0);
        chk("rst_dp_a", dp_a, 0);
        chk("rst_rsp_y", rsp_y, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single request, result 2 cycles after dp_start
        req = 4'b0001;
        tick();
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_start", dp_start, 1);
        chk("t1_dp_a", dp_a, 16'h0003);
        chk("t1_dp_b", dp_b, 16'h0004);
        chk("t1_busy", busy, 1);
        req = '0;
        tick();
        chk("t1_gnt_pulse", gnt, 0);
        chk("t1_start_pulse", dp_start, 0);
        tick();
        dp_valid = 1'b1;
        dp_y     = 16'h0007;
        tick();
        dp_valid = 1'b0;
        chk("t1_rsp", rsp_valid, 4'b0001);
        chk("t1_rsp_y", rsp_y, 16'h0007);
        chk("t1_idle", busy, 0);
        tick();
        chk("t1_rsp_pulse", rsp_valid, 0);

        // All requesters: fresh reset so the pointer starts at 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < N; k++) begin
            tick();
            chk("t2_gnt", gnt, 4'b0001 << k);
            req[k] = 1'b0;
            tick();
            dp_valid = 1'b1;
            dp_y     = W'(16'h0100 + k);
            tick();
            dp_valid = 1'b0;
            chk("t2_rsp", rsp_valid, 4'b0001 << k);
            chk("t2_rsp_y", rsp_y, 16'h0100 + k);
        end
        // Pointer back at 0: 0 beats 3
        op("t2_ptr0", 4'b1001, 4'b0001, 16'h0011);

        // Wrap: grant 2 leaves ptr=3, then 0101 goes to 0, leaving ptr=1
        op("t3_g2", 4'b0100, 4'b0100, 16'h0021);
        op("t3_wrap", 4'b0101, 4'b0001, 16'h0022);
        op("t3_ptr1", 4'b0011, 4'b0010, 16'h0033);

        // Timeout: datapath never answers
        req = 4'b0010;
        tick();
        chk("t4_gnt", gnt, 4'b0010);
        req = '0;
        tick();
        for (int i = 1; i < 15; i++) begin
            tick();
            chk("t4_no_tmo", tmo_err, 0);
        end
        chk("t4_busy_late", busy, 1);
        tick();
        chk("t4_tmo", tmo_err, 1);
        chk("t4_no_rsp", rsp_valid, 0);
        chk("t4_rsp_y_kept", rsp_y, 16'h0033);
        chk("t4_idle", busy, 0);
        tick();
        chk("t4_tmo_pulse", tmo_err, 0);
        op("t4_next", 4'b0100, 4'b0100, 16'h0044);

        // Reset in the middle of WAIT
        req = 4'b1000;
        tick();
        chk("t5_gnt", gnt, 4'b1000);
        chk("t5_dp_a", dp_a, 16'h0055);
        req = '0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_dp_a_clr", dp_a, 0);
        chk("t5_dp_b_clr", dp_b, 0);
        chk("t5_rsp_y_clr", rsp_y, 0);
        tick();
        rst_n    = 1'b1;
        dp_valid = 1'b1;
        dp_y     = 16'h0BAD;
        tick();
        dp_valid = 1'b0;
        chk("t5_late_rsp", rsp_valid, 0);
        chk("t5_late_busy", busy, 0);
        op("t5_ptr0", 4'b1001, 4'b0001, 16'h0055);

        // Stray dp_valid in IDLE and in the ISSUE cycle
        dp_valid = 1'b1;
        dp_y     = 16'h0BAD;
        tick();
        chk("t6_idle_rsp", rsp_valid, 0);
        chk("t6_idle_busy", busy, 0);
        dp_valid = 1'b0;
        req      = 4'b0010;
        tick();
        chk("t6_gnt", gnt, 4'b0010);
        req      = '0;
        dp_valid = 1'b1;
        tick();
        dp_valid = 1'b0;
        chk("t6_issue_rsp", rsp_valid, 0);
        chk("t6_wait_busy", busy, 1);
        tick();
        dp_valid = 1'b1;
        dp_y     = 16'h1234;
        tick();
        dp_valid = 1'b0;
        chk("t6_rsp", rsp_valid, 4'b0010);
        chk("t6_rsp_y", rsp_y, 16'h1234);
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
